// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: digit-serial adder/subtractor.
// Each cycle, one DIGIT-bit ripple-carry slice consumes DIGIT bits of both
// operands. A WIDTH-bit operation therefore takes N = WIDTH/DIGIT cycles.
// In subtract mode B is inverted and the carry-in is flipped when the
// operation is accepted, so the slice itself only ever adds.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  // One DIGIT-bit ripple-carry slice fed by the low digits of the shift
  // registers. c_chain[DIGIT-1] is the carry into the slice MSB, which on
  // the last digit is the carry into bit WIDTH-1 (needed for V).
  logic [DIGIT:0]   c_chain;
  logic [DIGIT-1:0] slice_sum;
  logic [WIDTH-1:0] final_res;

  assign c_chain[0] = carry_q;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
      assign slice_sum[gi]   = a_q[gi] ^ b_q[gi] ^ c_chain[gi];
      assign c_chain[gi + 1] = (a_q[gi] & b_q[gi]) |
                               (c_chain[gi] & (a_q[gi] ^ b_q[gi]));
    end
  endgenerate

  // Partial-result register: completed digits enter at the top and shift
  // right, so after the last digit the current slice sum joins them to form
  // the full result. With a single digit there is nothing to store.
  generate
    if (N > 1) begin : g_partial
      logic [WIDTH-DIGIT-1:0] p_q, p_d;

      assign final_res = {slice_sum, p_q};
      assign p_d       = final_res[WIDTH-1:DIGIT];

      // Shift the partial result only while digits are being processed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_q <= '0;
        end else if (state_q == RUN) begin
          p_q <= p_d;
        end
      end
    end else begin : g_single
      assign final_res = slice_sum;
    end
  endgenerate

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{Sub}};
          carry_d = Cin ^ Sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = c_chain[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          s_d     = final_res;
          cout_d  = c_chain[DIGIT];
          v_d     = c_chain[DIGIT-1] ^ c_chain[DIGIT];
          z_d     = (final_res == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // Register the sequencer, datapath and all outputs; reset aborts any
  // in-flight operation without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign S     = s_q;
  assign Cout  = cout_q;
  assign V     = v_q;
  assign Z     = z_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (DIGIT = 1, 4, 16 with
// WIDTH = 16) share operand inputs but have private start lines. Expected
// results go into a per-instance queue when an operation is launched and
// are popped when that instance pulses done.
module tb_digit_serial_addsub;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        v;
    logic        z;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        cin_in = 1'b0;
  logic        sub_in = 1'b0;

  logic        start_w [3];
  logic        rdy_w   [3];
  logic        done_w  [3];
  logic [15:0] s_w     [3];
  logic        cout_w  [3];
  logic        v_w     [3];
  logic        z_w     [3];

  exp_t sb [3][$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .Sub(sub_in),
    .A(a_in), .B(b_in), .Cin(cin_in), .ready(rdy_w[0]), .done(done_w[0]),
    .S(s_w[0]), .Cout(cout_w[0]), .V(v_w[0]), .Z(z_w[0]));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .Sub(sub_in),
    .A(a_in), .B(b_in), .Cin(cin_in), .ready(rdy_w[1]), .done(done_w[1]),
    .S(s_w[1]), .Cout(cout_w[1]), .V(v_w[1]), .Z(z_w[1]));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .Sub(sub_in),
    .A(a_in), .B(b_in), .Cin(cin_in), .ready(rdy_w[2]), .done(done_w[2]),
    .S(s_w[2]), .Cout(cout_w[2]), .V(v_w[2]), .Z(z_w[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 16 : ((d == 1) ? 4 : 1);
  endfunction

  function automatic exp_t mk(input logic [15:0] s, input logic cout,
                              input logic v, input logic z);
    exp_t e;
    e.s = s; e.cout = cout; e.v = v; e.z = z; e.done_cyc = 0;
    return e;
  endfunction

  // Reference: plain 17-bit addition; overflow from operand/result signs.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] sum;
    bb  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? ~cin : cin)};
    return mk(sum[15:0], sum[16],
              (a[15] == bb[15]) && (sum[15] != a[15]),
              (sum[15:0] == 16'd0));
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then check handshake and any completed result.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("ready_d%0d", d), rdy_w[d], (sb[d].size() == 0));
      if (done_w[d]) begin
        if (sb[d].size() == 0) begin
          check($sformatf("spurious_done_d%0d", d), done_w[d], 1'b0);
        end else begin
          e = sb[d].pop_front();
          $display("done d%0d cyc=%0d S=%h Cout=%b V=%b Z=%b",
                   d, cyc, s_w[d], cout_w[d], v_w[d], z_w[d]);
          check($sformatf("S_d%0d", d),       s_w[d],    e.s);
          check($sformatf("Cout_d%0d", d),    cout_w[d], e.cout);
          check($sformatf("V_d%0d", d),       v_w[d],    e.v);
          check($sformatf("Z_d%0d", d),       z_w[d],    e.z);
          check($sformatf("latency_d%0d", d), cyc,       e.done_cyc);
        end
      end
    end
  endtask

  task automatic check_zero(input int d);
    check($sformatf("rst_S_d%0d", d),    s_w[d],    16'd0);
    check($sformatf("rst_Cout_d%0d", d), cout_w[d], 1'b0);
    check($sformatf("rst_V_d%0d", d),    v_w[d],    1'b0);
    check($sformatf("rst_Z_d%0d", d),    z_w[d],    1'b0);
    check($sformatf("rst_done_d%0d", d), done_w[d], 1'b0);
  endtask

  task automatic launch(input logic [2:0] mask, input logic [15:0] a,
                        input logic [15:0] b, input logic cin,
                        input logic sub, input exp_t e);
    exp_t ee;
    a_in = a; b_in = b; cin_in = cin; sub_in = sub;
    for (int d = 0; d < 3; d++) begin
      if (mask[d]) begin
        ee = e;
        ee.done_cyc = cyc + 1 + lat_of(d);
        sb[d].push_back(ee);
        start_w[d] = 1'b1;
      end
    end
    tick();
    for (int d = 0; d < 3; d++) start_w[d] = 1'b0;
  endtask

  // Wait (bounded) for every queued result, then one cycle back to IDLE.
  task automatic wait_all();
    int guard;
    guard = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && guard < 60) begin
      tick();
      guard++;
    end
    check("done_timeout", sb[0].size() + sb[1].size() + sb[2].size(), 0);
    for (int d = 0; d < 3; d++) sb[d].delete();
    tick();
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rs;

    for (int d = 0; d < 3; d++) start_w[d] = 1'b0;

    // Reset held three cycles, then released: outputs stay zero.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int d = 0; d < 3; d++) check_zero(d);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int d = 0; d < 3; d++) check_zero(d);
    end

    // Directed operations on the DIGIT=4 instance.
    launch(3'b010, 16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 1'b0, 1'b0, 1'b0));
    wait_all();
    launch(3'b010, 16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
    wait_all();
    launch(3'b010, 16'h0007, 16'h0005, 1'b0, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b0));
    wait_all();
    launch(3'b010, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0));
    wait_all();
    launch(3'b010, 16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    wait_all();
    launch(3'b010, 16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
    wait_all();

    // start pulsed with new operands mid-RUN must be ignored.
    launch(3'b010, 16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0));
    tick();
    a_in = 16'hFFFF; b_in = 16'hFFFF; sub_in = 1'b1; start_w[1] = 1'b1;
    tick();
    start_w[1] = 1'b0;
    wait_all();

    // Reset mid-RUN: no done, outputs cleared, next operation correct.
    launch(3'b010, 16'h0F0F, 16'h0101, 1'b0, 1'b0, mk(16'h1010, 1'b0, 1'b0, 1'b0));
    tick();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) sb[d].delete();
    tick();
    check_zero(1);
    tick();
    rst_n = 1'b1;
    tick();
    check_zero(1);
    tick();
    check_zero(1);
    launch(3'b010, 16'hABCD, 16'h1234, 1'b0, 1'b0, mk(16'hBE01, 1'b0, 1'b0, 1'b0));
    wait_all();

    // Random sweep on all three instances against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      launch(3'b111, ra, rb, rc, rs, model(ra, rb, rc, rs));
      wait_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
